fft_in_bitrev_buf: RTL and testbench

Upstream input stage for the 8-point radix-2 DIT FFT core. It accepts a serial stream of complex Q1.15 samples over a valid/ready handshake. Each sample is written into bit-reversed position within a ping-pong pair of 8-entry frame banks. Each completed frame is presented as a parallel, registered 8-sample vector on the exact port shape the FFT core consumes, with a frame-level valid/ready handshake.

---
 rtl/fft_in_bitrev_buf.sv | 106 ++++++++++
 tb/tb_fft_in_bitrev_buf.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_in_bitrev_buf.sv
// rtl/fft_in_bitrev_buf.sv - serial-to-frame input stage writing samples into bit-reversed ping-pong banks.
// Optional 1/8 input pre-scaling is enabled by defining FFT_IN_SCALE_EN.
module fft_in_bitrev_buf #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [W-1:0] s_re,
   input  logic [W-1:0] s_im,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [W-1:0] m_re [0:7],
   output logic [W-1:0] m_im [0:7],
   output logic [7:0]   frame_cnt
);

   logic [W-1:0] mem_re [0:1][0:7];
   logic [W-1:0] mem_im [0:1][0:7];
   logic [1:0]   full;
   logic         wr_bank;
   logic         rd_bank;
   logic [2:0]   idx;
   logic [W-1:0] in_re;
   logic [W-1:0] in_im;
   logic         wr_en;
   logic         rd_en;
   logic         wr_last;

   function automatic logic [2:0] bitrev3(input logic [2:0] i);
      return {i[0], i[1], i[2]};
   endfunction

`ifdef FFT_IN_SCALE_EN
   // Arithmetic shift gives floor division, keeping three unscaled stages in range.
   assign in_re = $signed(s_re) >>> 3;
   assign in_im = $signed(s_im) >>> 3;
`else
   assign in_re = s_re;
   assign in_im = s_im;
`endif

   assign s_ready = !full[wr_bank];
   assign m_valid = full[rd_bank];
   // clr blocks both handshakes so storage is untouched by a clearing cycle.
   assign wr_en   = s_valid && s_ready && !clr;
   assign rd_en   = m_valid && m_ready && !clr;
   assign wr_last = (idx == 3'd7);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int e = 0; e < 8; e++) begin
               mem_re[b][e] <= '0;
               mem_im[b][e] <= '0;
            end
         end
      end else if (wr_en) begin
         mem_re[wr_bank][bitrev3(idx)] <= in_re;
         mem_im[wr_bank][bitrev3(idx)] <= in_im;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full      <= 2'b00;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         idx       <= 3'd0;
         frame_cnt <= 8'd0;
      end else if (clr) begin
         full      <= 2'b00;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         idx       <= 3'd0;
         frame_cnt <= 8'd0;
      end else begin
         // A write can only complete into an empty bank and a read only drains a full one,
         // so the two updates below never touch the same flag bit.
         if (wr_en) begin
            if (wr_last) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
               idx           <= 3'd0;
            end else begin
               idx <= idx + 3'd1;
            end
         end
         if (rd_en) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
            frame_cnt     <= frame_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         m_re[i] = mem_re[rd_bank][i];
         m_im[i] = mem_im[rd_bank][i];
      end
   end

endmodule

// File: tb/tb_fft_in_bitrev_buf.sv
// tb/tb_fft_in_bitrev_buf.sv - randomized self-checking bench with a queue-based frame model.
module tb_fft_in_bitrev_buf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clr = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_re = '0;
   logic [15:0] s_im = '0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [15:0] m_re [0:7];
   logic [15:0] m_im [0:7];
   logic [7:0]  frame_cnt;

   int vectors = 0;
   int errs = 0;

   // Model: completed frames in arrival order, flattened, plus the partial frame.
   logic [15:0] fr_re[$];
   logic [15:0] fr_im[$];
   logic [15:0] part_re[$];
   logic [15:0] part_im[$];
   int          exp_cnt = 0;
   int          seq8 [0:7] = '{0, 4, 2, 6, 1, 5, 3, 7};

   fft_in_bitrev_buf #(.W(16)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
      .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   function automatic int bitrev(input int j);
      return (j % 2) * 4 + ((j / 2) % 2) * 2 + j / 4;
   endfunction

   function automatic logic [15:0] scl(input logic [15:0] v);
`ifdef FFT_IN_SCALE_EN
      int sv;
      sv = int'($signed(v));
      if (sv >= 0) sv = sv / 8;
      else sv = -((-sv + 7) / 8);
      return 16'(sv);
`else
      return v;
`endif
   endfunction

   task automatic model_reset();
      fr_re.delete(); fr_im.delete(); part_re.delete(); part_im.delete();
      exp_cnt = 0;
   endtask

   task automatic tick();
      bit acc, cons;
      acc  = s_valid && (fr_re.size() < 16) && !clr;
      cons = m_ready && (fr_re.size() >= 8) && !clr;
      @(posedge clk); #1;
      if (clr) begin
         model_reset();
      end else begin
         if (cons) begin
            for (int i = 0; i < 8; i++) begin
               void'(fr_re.pop_front());
               void'(fr_im.pop_front());
            end
            exp_cnt = (exp_cnt + 1) % 256;
         end
         if (acc) begin
            part_re.push_back(scl(s_re));
            part_im.push_back(scl(s_im));
            if (part_re.size() == 8) begin
               for (int i = 0; i < 8; i++) begin
                  fr_re.push_back(part_re[i]);
                  fr_im.push_back(part_im[i]);
               end
               part_re.delete(); part_im.delete();
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      vectors++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0 || frame_cnt !== 8'd0)
         $display("FAIL reset_ctrl: s_ready=%b m_valid=%b frame_cnt=%0d, required 1 0 0", s_ready, m_valid, frame_cnt);
      if (s_ready !== 1'b1 || m_valid !== 1'b0 || frame_cnt !== 8'd0) errs++;
      for (int j = 0; j < 8; j++) begin
         vectors++;
         if (m_re[j] !== 16'h0 || m_im[j] !== 16'h0) begin
            errs++;
            $display("FAIL reset_data[%0d]: re=%h im=%h, required 0 0", j, m_re[j], m_im[j]);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_stream8();
      m_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         s_valid = 1'b1; s_re = 16'(k); s_im = 16'h0;
         vectors++;
         if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errs++;
            $display("FAIL stream8_pre[%0d]: s_ready=%b m_valid=%b, required 1 0", k, s_ready, m_valid);
         end
         tick();
      end
      s_valid = 1'b0;
      vectors++;
      if (m_valid !== 1'b1 || frame_cnt !== 8'd0) begin
         errs++;
         $display("FAIL stream8_valid: m_valid=%b frame_cnt=%0d, required 1 0", m_valid, frame_cnt);
      end
      for (int j = 0; j < 8; j++) begin
         vectors++;
         if (m_re[j] !== scl(16'(seq8[j])) || m_im[j] !== 16'h0) begin
            errs++;
            $display("FAIL stream8_data[%0d]: re=%h im=%h, required %h 0", j, m_re[j], m_im[j], scl(16'(seq8[j])));
         end
      end
      tick();
      vectors++;
      if (frame_cnt !== 8'd1 || m_valid !== 1'b0) begin
         errs++;
         $display("FAIL stream8_consume: frame_cnt=%0d m_valid=%b, required 1 0", frame_cnt, m_valid);
      end
   endtask

   task automatic test_backpressure();
      m_ready = 1'b0;
      for (int k = 0; k < 16; k++) begin
         s_valid = 1'b1; s_re = 16'($urandom); s_im = 16'($urandom);
         vectors++;
         if (s_ready !== 1'b1) begin
            errs++;
            $display("FAIL bp_fill[%0d]: s_ready=%b, required 1", k, s_ready);
         end
         tick();
      end
      for (int c = 0; c < 4; c++) begin
         s_re = 16'($urandom); s_im = 16'($urandom);
         vectors++;
         if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
            errs++;
            $display("FAIL bp_hold[%0d]: s_ready=%b m_valid=%b, required 0 1", c, s_ready, m_valid);
         end
         for (int j = 0; j < 8; j++) begin
            vectors++;
            if (m_re[j] !== fr_re[bitrev(j)] || m_im[j] !== fr_im[bitrev(j)]) begin
               errs++;
               $display("FAIL bp_stable[%0d]: re=%h im=%h, required %h %h", j, m_re[j], m_im[j], fr_re[bitrev(j)], fr_im[bitrev(j)]);
            end
         end
         tick();
      end
      s_valid = 1'b0; m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      vectors++;
      if (s_ready !== 1'b1 || m_valid !== 1'b1 || frame_cnt !== 8'(exp_cnt)) begin
         errs++;
         $display("FAIL bp_release: s_ready=%b m_valid=%b frame_cnt=%0d, required 1 1 %0d", s_ready, m_valid, frame_cnt, exp_cnt);
      end
      for (int j = 0; j < 8; j++) begin
         vectors++;
         if (m_re[j] !== fr_re[bitrev(j)] || m_im[j] !== fr_im[bitrev(j)]) begin
            errs++;
            $display("FAIL bp_frame2[%0d]: re=%h im=%h, required %h %h", j, m_re[j], m_im[j], fr_re[bitrev(j)], fr_im[bitrev(j)]);
         end
      end
      for (int k = 0; k < 8; k++) begin
         s_valid = 1'b1; s_re = 16'($urandom); s_im = 16'($urandom);
         vectors++;
         if (s_ready !== 1'b1) begin
            errs++;
            $display("FAIL bp_refill[%0d]: s_ready=%b, required 1", k, s_ready);
         end
         tick();
      end
      s_valid = 1'b0; m_ready = 1'b1;
      for (int c = 0; c < 4 && fr_re.size() > 0; c++) begin
         vectors++;
         if (m_valid !== 1'b1) begin
            errs++;
            $display("FAIL bp_drain_valid[%0d]: m_valid=%b, required 1", c, m_valid);
         end
         for (int j = 0; j < 8; j++) begin
            vectors++;
            if (m_re[j] !== fr_re[bitrev(j)] || m_im[j] !== fr_im[bitrev(j)]) begin
               errs++;
               $display("FAIL bp_drain[%0d]: re=%h im=%h, required %h %h", j, m_re[j], m_im[j], fr_re[bitrev(j)], fr_im[bitrev(j)]);
            end
         end
         tick();
      end
      vectors++;
      if (m_valid !== 1'b0 || frame_cnt !== 8'(exp_cnt)) begin
         errs++;
         $display("FAIL bp_end: m_valid=%b frame_cnt=%0d, required 0 %0d", m_valid, frame_cnt, exp_cnt);
      end
   endtask

   task automatic test_continuous();
      clr = 1'b1; tick(); clr = 1'b0;
      m_ready = 1'b1;
      for (int k = 0; k < 64; k++) begin
         s_valid = 1'b1; s_re = 16'(k); s_im = 16'($urandom);
         vectors++;
         if (s_ready !== 1'b1 || m_valid !== (fr_re.size() >= 8)) begin
            errs++;
            $display("FAIL cont_hs[%0d]: s_ready=%b m_valid=%b, required 1 %b", k, s_ready, m_valid, fr_re.size() >= 8);
         end
         if (fr_re.size() >= 8) begin
            for (int j = 0; j < 8; j++) begin
               vectors++;
               if (m_re[j] !== fr_re[bitrev(j)] || m_im[j] !== fr_im[bitrev(j)]) begin
                  errs++;
                  $display("FAIL cont_data[%0d/%0d]: re=%h im=%h, required %h %h", k, j, m_re[j], m_im[j], fr_re[bitrev(j)], fr_im[bitrev(j)]);
               end
            end
         end
         tick();
      end
      s_valid = 1'b0;
      tick();
      vectors++;
      if (frame_cnt !== 8'd8 || m_valid !== 1'b0) begin
         errs++;
         $display("FAIL cont_count: frame_cnt=%0d m_valid=%b, required 8 0", frame_cnt, m_valid);
      end
   endtask

   task automatic test_clr();
      m_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         s_valid = 1'b1; s_re = 16'($urandom); s_im = 16'($urandom);
         tick();
      end
      clr = 1'b1; tick(); clr = 1'b0;
      vectors++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1 || frame_cnt !== 8'd0) begin
         errs++;
         $display("FAIL clr_state: m_valid=%b s_ready=%b frame_cnt=%0d, required 0 1 0", m_valid, s_ready, frame_cnt);
      end
      for (int k = 0; k < 8; k++) begin
         s_valid = 1'b1; s_re = 16'(100 + k); s_im = 16'(k);
         tick();
      end
      s_valid = 1'b0;
      vectors++;
      if (m_valid !== 1'b1 || frame_cnt !== 8'd0) begin
         errs++;
         $display("FAIL clr_frame_valid: m_valid=%b frame_cnt=%0d, required 1 0", m_valid, frame_cnt);
      end
      for (int j = 0; j < 8; j++) begin
         vectors++;
         if (m_re[j] !== scl(16'(100 + seq8[j])) || m_im[j] !== scl(16'(seq8[j]))) begin
            errs++;
            $display("FAIL clr_frame[%0d]: re=%h im=%h, required %h %h", j, m_re[j], m_im[j], scl(16'(100 + seq8[j])), scl(16'(seq8[j])));
         end
      end
      m_ready = 1'b1; tick(); m_ready = 1'b0;
      vectors++;
      if (frame_cnt !== 8'd1) begin
         errs++;
         $display("FAIL clr_consume: frame_cnt=%0d, required 1", frame_cnt);
      end
   endtask

   task automatic test_reset_mid();
      m_ready = 1'b0;
      for (int k = 0; k < 11; k++) begin
         s_valid = 1'b1; s_re = 16'($urandom) | 16'h1; s_im = 16'($urandom);
         tick();
      end
      s_valid = 1'b0;
      vectors++;
      if (m_valid !== 1'b1) begin
         errs++;
         $display("FAIL rstmid_pre: m_valid=%b, required 1", m_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1 || frame_cnt !== 8'd0) begin
         errs++;
         $display("FAIL rstmid_ctrl: m_valid=%b s_ready=%b frame_cnt=%0d, required 0 1 0", m_valid, s_ready, frame_cnt);
      end
      for (int j = 0; j < 8; j++) begin
         vectors++;
         if (m_re[j] !== 16'h0 || m_im[j] !== 16'h0) begin
            errs++;
            $display("FAIL rstmid_data[%0d]: re=%h im=%h, required 0 0", j, m_re[j], m_im[j]);
         end
      end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         s_valid = ($urandom % 4) != 0;
         m_ready = ($urandom % 2) != 0;
         clr     = ($urandom % 64) == 0;
         s_re = 16'($urandom); s_im = 16'($urandom);
         vectors++;
         if (s_ready !== (fr_re.size() < 16) || m_valid !== (fr_re.size() >= 8) || frame_cnt !== 8'(exp_cnt)) begin
            errs++;
            $display("FAIL rand_ctrl[%0d]: s_ready=%b m_valid=%b frame_cnt=%0d, required %b %b %0d", c, s_ready, m_valid, frame_cnt, fr_re.size() < 16, fr_re.size() >= 8, exp_cnt);
         end
         if (fr_re.size() >= 8) begin
            for (int j = 0; j < 8; j++) begin
               vectors++;
               if (m_re[j] !== fr_re[bitrev(j)] || m_im[j] !== fr_im[bitrev(j)]) begin
                  errs++;
                  $display("FAIL rand_data[%0d/%0d]: re=%h im=%h, required %h %h", c, j, m_re[j], m_im[j], fr_re[bitrev(j)], fr_im[bitrev(j)]);
               end
            end
         end
         tick();
      end
      clr = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
   endtask

`ifdef FFT_IN_SCALE_EN
   task automatic test_scale();
      clr = 1'b1; tick(); clr = 1'b0;
      m_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         s_valid = 1'b1; s_re = 16'h7FFF; s_im = 16'h8000;
         tick();
      end
      s_valid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         vectors++;
         if (m_valid !== 1'b1 || m_re[j] !== 16'h0FFF || m_im[j] !== 16'hF000) begin
            errs++;
            $display("FAIL scale[%0d]: valid=%b re=%h im=%h, required 1 0fff f000", j, m_valid, m_re[j], m_im[j]);
         end
      end
   endtask
`endif

   initial begin
      #1;
      test_reset();
      test_stream8();
      test_backpressure();
      test_continuous();
      test_clr();
      test_reset_mid();
      test_random();
`ifdef FFT_IN_SCALE_EN
      test_scale();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
